// File: rtl/lab4_branch_update_queue_pkg.sv
// Shared types for the branch update queue.
// Holds the PC width and the stored branch entry layout.
package lab4_branch_pkg;

  localparam int PC_W = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred;
  } bq_entry_t;

endpackage

// File: rtl/lab4_branch_update_queue_if.sv
// Fetch/execute/predictor side bundle of the branch update queue.
// master drives requests, slave is the queue itself.
interface lab4_branch_update_queue_if #(
    parameter int p_depth = 4
);
    import lab4_branch_pkg::*;

    logic                     alloc_val;
    logic                     alloc_rdy;
    logic [PC_W-1:0]          alloc_pc;
    logic                     alloc_pred;
    logic                     resolve_val;
    logic                     resolve_taken;
    logic                     resolve_rdy;
    logic                     flush;
    logic                     update_en;
    logic                     update_val;
    logic [PC_W-1:0]          update_pc;
    logic                     mispredict;
    logic [$clog2(p_depth):0] count;

    modport master (
        output alloc_val, alloc_pc, alloc_pred,
        output resolve_val, resolve_taken, flush,
        input  alloc_rdy, resolve_rdy,
        input  update_en, update_val, update_pc,
        input  mispredict, count
    );

    modport slave (
        input  alloc_val, alloc_pc, alloc_pred,
        input  resolve_val, resolve_taken, flush,
        output alloc_rdy, resolve_rdy,
        output update_en, update_val, update_pc,
        output mispredict, count
    );

endinterface

// File: rtl/lab4_branch_uq_storage.sv
// Entry array for the branch update queue.
// One synchronous write port, one combinational read port.
module lab4_branch_uq_storage
    import lab4_branch_pkg::*;
#(
    parameter int p_depth = 4,
    localparam int PW = $clog2(p_depth)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  bq_entry_t     wdata,
    input  logic [PW-1:0] raddr,
    output bq_entry_t     rdata
);

    bq_entry_t mem [p_depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lab4_branch_update_queue.sv
// In-flight branch queue feeding resolved outcomes back to the predictor.
// Define LAB4_BRANCH_UPDATE_QUEUE_STATS_EN for resolve/mispredict counters.
module lab4_branch_update_queue
    import lab4_branch_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    lab4_branch_update_queue_if.slave  bus
`ifdef LAB4_BRANCH_UPDATE_QUEUE_STATS_EN
    ,
    output logic [31:0]                num_resolved,
    output logic [31:0]                num_mispred
`endif
);

    localparam int PW = $clog2(p_depth);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   cnt;
    logic          alloc_fire;
    logic          resolve_fire;
    bq_entry_t     wr_entry;
    bq_entry_t     rd_entry;

    assign bus.alloc_rdy   = (cnt != (PW+1)'(p_depth));
    assign bus.resolve_rdy = (cnt != '0);
    assign bus.count       = cnt;

    // flush wins over both handshakes
    assign alloc_fire   = bus.alloc_val & bus.alloc_rdy & ~bus.flush;
    assign resolve_fire = bus.resolve_val & bus.resolve_rdy & ~bus.flush;

    assign wr_entry.pc   = bus.alloc_pc;
    assign wr_entry.pred = bus.alloc_pred;

    lab4_branch_uq_storage #(
        .p_depth (p_depth)
    ) u_storage (
        .clk   (clk),
        .we    (alloc_fire),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (bus.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + PW'(1);
            end
            if (resolve_fire) begin
                head <= head + PW'(1);
            end
            if (alloc_fire && !resolve_fire) begin
                cnt <= cnt + (PW+1)'(1);
            end else if (!alloc_fire && resolve_fire) begin
                cnt <= cnt - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.update_en  <= 1'b0;
            bus.update_val <= 1'b0;
            bus.update_pc  <= '0;
            bus.mispredict <= 1'b0;
        end else begin
            bus.update_en  <= resolve_fire;
            bus.mispredict <= resolve_fire &
                              (rd_entry.pred != bus.resolve_taken);
            if (resolve_fire) begin
                bus.update_val <= bus.resolve_taken;
                bus.update_pc  <= rd_entry.pc;
            end
        end
    end

`ifdef LAB4_BRANCH_UPDATE_QUEUE_STATS_EN
    // bumped on the same edge that raises update_en / mispredict
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            num_resolved <= '0;
            num_mispred  <= '0;
        end else if (resolve_fire) begin
            num_resolved <= num_resolved + 32'd1;
            if (rd_entry.pred != bus.resolve_taken) begin
                num_mispred <= num_mispred + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lab4_branch_update_queue.sv
// Directed bench for the branch update queue, depth 4.
// Inputs change 1 time unit after posedge; outputs sampled there too.
module tb_lab4_branch_update_queue;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lab4_branch_update_queue_if #(.p_depth(4)) bus ();

    lab4_branch_update_queue #(
        .p_depth (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [31:0] pc,
                         input logic pred, input logic rv,
                         input logic tk, input logic fl);
        bus.alloc_val     = av;
        bus.alloc_pc      = pc;
        bus.alloc_pred    = pred;
        bus.resolve_val   = rv;
        bus.resolve_taken = tk;
        bus.flush         = fl;
        step();
        bus.alloc_val   = 1'b0;
        bus.resolve_val = 1'b0;
        bus.flush       = 1'b0;
    endtask

    logic [31:0] exp_pc [4];
    logic        exp_mis [4];

    initial begin
        bus.alloc_val     = 1'b0;
        bus.alloc_pc      = '0;
        bus.alloc_pred    = 1'b0;
        bus.resolve_val   = 1'b0;
        bus.resolve_taken = 1'b0;
        bus.flush         = 1'b0;
        #2;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_alloc_rdy", 32'(bus.alloc_rdy), 1);
        chk("rst_resolve_rdy", 32'(bus.resolve_rdy), 0);
        chk("rst_update_en", 32'(bus.update_en), 0);
        chk("rst_update_pc", bus.update_pc, 0);
        chk("rst_mispredict", 32'(bus.mispredict), 0);
        step();
        reset = 1'b1;
        step();

        // single alloc then mispredicted resolve
        drive(1, 32'h20C, 0, 0, 0, 0);
        chk("a1_count", 32'(bus.count), 1);
        chk("a1_resolve_rdy", 32'(bus.resolve_rdy), 1);
        drive(0, 0, 0, 1, 1, 0);
        chk("r1_update_en", 32'(bus.update_en), 1);
        chk("r1_update_val", 32'(bus.update_val), 1);
        chk("r1_update_pc", bus.update_pc, 32'h20C);
        chk("r1_mispredict", 32'(bus.mispredict), 1);
        chk("r1_count", 32'(bus.count), 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("idle_update_en", 32'(bus.update_en), 0);
        chk("idle_mispredict", 32'(bus.mispredict), 0);
        chk("idle_update_pc_hold", bus.update_pc, 32'h20C);
        chk("idle_update_val_hold", 32'(bus.update_val), 1);

        // fill, overflow attempt, drain in order
        exp_pc  = '{32'h100, 32'h104, 32'h108, 32'h10C};
        exp_mis = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive(1, exp_pc[i], ~exp_mis[i], 0, 0, 0);
        end
        chk("full_count", 32'(bus.count), 4);
        chk("full_alloc_rdy", 32'(bus.alloc_rdy), 0);
        drive(1, 32'h200, 1, 0, 0, 0);
        chk("over_count", 32'(bus.count), 4);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 1, 0);
            chk($sformatf("drain%0d_pc", i), bus.update_pc, exp_pc[i]);
            chk($sformatf("drain%0d_mis", i), 32'(bus.mispredict),
                32'(exp_mis[i]));
        end
        chk("drained_count", 32'(bus.count), 0);

        // full with simultaneous alloc + resolve, then wrap
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h300 + 32'(i * 4), 0, 0, 0, 0);
        end
        drive(1, 32'h400, 1, 1, 0, 0);
        chk("fullar_count", 32'(bus.count), 3);
        chk("fullar_pc", bus.update_pc, 32'h300);
        chk("fullar_mis", 32'(bus.mispredict), 0);
        drive(1, 32'h400, 1, 0, 0, 0);
        chk("refill_count", 32'(bus.count), 4);
        exp_pc  = '{32'h304, 32'h308, 32'h30C, 32'h400};
        exp_mis = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 1, 1, 0);
            chk($sformatf("wrap%0d_pc", i), bus.update_pc, exp_pc[i]);
            chk($sformatf("wrap%0d_mis", i), 32'(bus.mispredict),
                32'(exp_mis[i]));
        end

        // count 2, concurrent alloc + resolve
        drive(1, 32'h500, 1, 0, 0, 0);
        drive(1, 32'h504, 0, 0, 0, 0);
        drive(1, 32'h508, 1, 1, 1, 0);
        chk("ar2_count", 32'(bus.count), 2);
        chk("ar2_pc", bus.update_pc, 32'h500);
        chk("ar2_en", 32'(bus.update_en), 1);

        // flush beats resolve and alloc
        drive(1, 32'h50C, 0, 0, 0, 0);
        chk("pre_flush_count", 32'(bus.count), 3);
        drive(1, 32'h510, 0, 1, 1, 1);
        chk("flush_count", 32'(bus.count), 0);
        chk("flush_update_en", 32'(bus.update_en), 0);
        chk("flush_resolve_rdy", 32'(bus.resolve_rdy), 0);
        chk("flush_alloc_rdy", 32'(bus.alloc_rdy), 1);
        drive(1, 32'h600, 0, 0, 0, 0);
        drive(1, 32'h604, 1, 1, 0, 0);
        chk("post_flush_pc", bus.update_pc, 32'h600);
        chk("post_flush_mis", 32'(bus.mispredict), 0);

        // async reset mid-stream
        drive(1, 32'h608, 0, 0, 0, 0);
        drive(1, 32'h60C, 0, 1, 1, 0);
        chk("prerst_count", 32'(bus.count), 2);
        chk("prerst_en", 32'(bus.update_en), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", 32'(bus.count), 0);
        chk("arst_update_en", 32'(bus.update_en), 0);
        chk("arst_update_pc", bus.update_pc, 0);
        chk("arst_update_val", 32'(bus.update_val), 0);
        chk("arst_mispredict", 32'(bus.mispredict), 0);
        chk("arst_resolve_rdy", 32'(bus.resolve_rdy), 0);
        step();
        reset = 1'b1;
        step();
        drive(1, 32'h700, 1, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        chk("postrst_pc", bus.update_pc, 32'h700);
        chk("postrst_mis", 32'(bus.mispredict), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab4_branch_update_queue.md
LAB4_BRANCH_UPDATE_QUEUE -- requirements
Module: lab4_branch_update_queue

Interface
REQ-001 SHALL have parameter p_depth, default 4, meaning the number of in-flight branch entries (power of 2, ≥2).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port alloc_val  input  1  fetch requests an entry for a predicted branch.
REQ-005 SHALL have port alloc_rdy  output  1  queue can accept an entry (not full).
REQ-006 SHALL have port alloc_pc  input  32  PC of the fetched branch.
REQ-007 SHALL have port alloc_pred  input  1  direction predicted by the GShare predictor.
REQ-008 SHALL have port resolve_val  input  1  execute resolves the oldest outstanding branch.
REQ-009 SHALL have port resolve_taken  input  1  actual branch outcome.
REQ-010 SHALL have port resolve_rdy  output  1  queue holds at least one entry (not empty).
REQ-011 SHALL have port flush  input  1  discard all outstanding entries.
REQ-012 SHALL have port update_en  output  1  registered write enable to the predictor.
REQ-013 SHALL have port update_val  output  1  registered resolved outcome to the predictor.
REQ-014 SHALL have port update_pc  output  32  registered PC of the resolved branch.
REQ-015 SHALL have port mispredict  output  1  registered; high with update_en when stored prediction != outcome.
REQ-016 SHALL have port count  output  $clog2(p_depth)+1  current occupancy.

Function
REQ-017 SHALL implement a circular FIFO with head/tail pointers wrapping modulo p_depth.
REQ-018 Alloc fire = alloc_val & alloc_rdy; SHALL write {alloc_pc, alloc_pred} at tail, advance tail, count+1.
REQ-019 Resolve fire = resolve_val & resolve_rdy; SHALL read the head entry, advance head, count-1.
REQ-020 alloc_rdy SHALL equal (count != p_depth), with no dependence on same-cycle resolve (no full bypass).
REQ-021 resolve_rdy SHALL equal (count != 0); an entry allocated in cycle N is resolvable in cycle N+1 at the earliest.
REQ-022 Simultaneous alloc and resolve fire SHALL leave count unchanged and move both pointers.
REQ-023 A resolve fire in cycle N SHALL produce in cycle N+1: update_en=1, update_val=resolve_taken, update_pc=head PC, mispredict=(head pred != resolve_taken).
REQ-024 Without a resolve fire, update_en and mispredict SHALL be 0 next cycle; update_val/update_pc SHALL hold their previous values.
REQ-025 flush SHALL have highest priority: next cycle count=0, head=tail=0; same-cycle alloc and resolve SHALL be suppressed, so update_en=0 next cycle.
REQ-026 resolve_val while empty and alloc_val while full SHALL be ignored with no state change.

Reset
REQ-027 Reset low SHALL immediately clear head, tail, and count, and set update_en, update_val, mispredict to 0 and update_pc to 32'h0.
REQ-028 After reset: alloc_rdy=1, resolve_rdy=0; storage contents are don't-care.
REQ-029 Reset asserted mid-operation SHALL discard all entries and any pending update in the same way.

Configuration
REQ-030 With LAB4_BRANCH_UPDATE_QUEUE_STATS_EN defined, SHALL add outputs num_resolved (32) and num_mispred (32), incremented on each update_en and each mispredict, cleared by reset but not by flush, wrapping at 2^32.
REQ-031 Without LAB4_BRANCH_UPDATE_QUEUE_STATS_EN, those ports and counters SHALL be absent, with all other behaviour identical.

Structure
REQ-032 Package lab4_branch_pkg SHALL hold the PC width constant (32) and the entry typedef {pc[31:0], pred}.
REQ-033 Entry storage SHALL be the sub-module lab4_branch_uq_storage: p_depth entries, 1 write and 1 combinational read port.

Verification
REQ-034 Reset, then alloc PC=0x20C with pred=0, then resolve taken=1 -> next cycle update_en=1, update_val=1, update_pc=0x20C, mispredict=1.
REQ-035 Allocate 4 entries (p_depth=4) -> count=4, alloc_rdy=0; a 5th alloc is ignored; 4 resolves return the PCs in FIFO order.
REQ-036 Full queue, alloc and resolve in the same cycle -> alloc ignored, count=3; next cycle alloc accepted, count=4; pointers wrap correctly.
REQ-037 Count=2, alloc and resolve in the same cycle -> count stays 2; update_pc equals the oldest PC.
REQ-038 Count=3, flush asserted together with resolve_val -> next cycle count=0, update_en=0, resolve_rdy=0.
REQ-039 Reset driven low mid-stream with count=2 -> outputs clear immediately; with STATS_EN, num_resolved=0.
